// File: rtl/booth_mul_arbiter.sv
// Round-robin arbiter/sequencer sharing one radix-4 Booth multiplier among N_REQ requesters.
// One operation in flight: IDLE accepts, ISSUE pulses start, WAIT qualifies done, RESP returns the product.
module booth_mul_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 16,
    localparam int unsigned IDW  = $clog2(N_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*WIDTH-1:0]   req_a,
    input  logic [N_REQ*WIDTH-1:0]   req_b,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     mul_start,
    output logic [WIDTH-1:0]         mul_a,
    output logic [WIDTH-1:0]         mul_b,
    input  logic                     mul_done,
    input  logic [2*WIDTH-1:0]       mul_product,
    output logic [N_REQ-1:0]         rsp_valid,
    output logic [2*WIDTH-1:0]       rsp_product,
    input  logic [N_REQ-1:0]         rsp_ready,
    output logic                     busy,
    output logic [IDW-1:0]           grant_id
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t             state_q, state_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [IDW-1:0]     grant_q, grant_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic               armed_q, armed_d;

    logic               win_vld;
    logic [IDW-1:0]     win_id;
    int unsigned        cand;

    // Search ptr, ptr+1, ... modulo N_REQ; first valid requester wins.
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        cand    = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = (32'(ptr_q) + i) % N_REQ;
            if (!win_vld && req_valid[IDW'(cand)]) begin
                win_vld = 1'b1;
                win_id  = IDW'(cand);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        a_d     = a_q;
        b_d     = b_q;
        prod_d  = prod_q;
        armed_d = armed_q;
        if (en) begin
            case (state_q)
                S_IDLE: begin
                    if (win_vld) begin
                        a_d     = req_a[win_id*WIDTH +: WIDTH];
                        b_d     = req_b[win_id*WIDTH +: WIDTH];
                        grant_d = win_id;
                        ptr_d   = (win_id == IDW'(N_REQ-1)) ? '0 : win_id + 1'b1;
                        state_d = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    armed_d = 1'b0;
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    // A done seen before it has dropped once belongs to the previous operation.
                    if (!mul_done) begin
                        armed_d = 1'b1;
                    end else if (armed_q) begin
                        prod_d  = mul_product;
                        state_d = S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready[grant_q]) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            prod_q  <= '0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            a_q     <= a_d;
            b_q     <= b_d;
            prod_q  <= prod_d;
            armed_q <= armed_d;
        end
    end

    assign req_ready   = (en && state_q == S_IDLE && win_vld) ? (N_REQ'(1) << win_id) : '0;
    assign rsp_valid   = (en && state_q == S_RESP) ? (N_REQ'(1) << grant_q) : '0;
    assign mul_start   = en && (state_q == S_ISSUE);
    assign mul_a       = a_q;
    assign mul_b       = b_q;
    assign rsp_product = prod_q;
    assign busy        = (state_q != S_IDLE);
    assign grant_id    = grant_q;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Scoreboard bench for booth_mul_arbiter with a behavioural sticky-done multiplier model.
module tb_booth_mul_arbiter;

    localparam int NR = 4;
    localparam int W  = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic [NR-1:0]     req_valid;
    logic [NR*W-1:0]   req_a, req_b;
    logic [NR-1:0]     req_ready;
    logic              mul_start;
    logic [W-1:0]      mul_a, mul_b;
    logic              mul_done;
    logic [2*W-1:0]    mul_product;
    logic [NR-1:0]     rsp_valid;
    logic [2*W-1:0]    rsp_product;
    logic [NR-1:0]     rsp_ready;
    logic              busy;
    logic [1:0]        grant_id;

    booth_mul_arbiter #(.N_REQ(NR), .WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_done(mul_done), .mul_product(mul_product),
        .rsp_valid(rsp_valid), .rsp_product(rsp_product), .rsp_ready(rsp_ready),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    // Multiplier model: done stays high stale_cfg cycles after start, then result after 4 more.
    int                stale_cfg = 1;
    int                stale_cnt, lat_cnt;
    logic signed [31:0] pend;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_done <= 1'b0; mul_product <= '0; stale_cnt <= 0; lat_cnt <= 0; pend <= '0;
        end else if (mul_start) begin
            pend      <= $signed(mul_a) * $signed(mul_b);
            stale_cnt <= stale_cfg;
            lat_cnt   <= 4;
            if (stale_cfg == 0) mul_done <= 1'b0;
        end else if (stale_cnt != 0) begin
            stale_cnt <= stale_cnt - 1;
            if (stale_cnt == 1) mul_done <= 1'b0;
        end else if (lat_cnt != 0) begin
            lat_cnt <= lat_cnt - 1;
            if (lat_cnt == 1) begin mul_done <= 1'b1; mul_product <= pend; end
        end
    end

    typedef struct { int id; logic [31:0] p; } rsp_t;
    rsp_t rq[$];
    int   gq[$];
    int   checks = 0;
    int   errors = 0;
    int   starts = 0;

    int          tab_id[8];
    logic [15:0] tab_a[8], tab_b[8];
    logic [31:0] tab_p[8];
    bit          used_e[8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout expected=event", nm);
    endtask

    // Monitor: pops the scoreboards on every grant and every response handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mul_start) starts++;
            if (|req_ready) begin
                chk("req_ready_onehot", 64'($onehot(req_ready)), 64'd1);
                if (gq.size() == 0) fail_now("unexpected_grant");
                else chk("grant_order", 64'(req_ready), 64'(4'b0001 << gq.pop_front()));
            end
            if (|(rsp_valid & rsp_ready)) begin
                if (rq.size() == 0) fail_now("unexpected_rsp");
                else begin
                    rsp_t e;
                    e = rq.pop_front();
                    chk("rsp_valid_id", 64'(rsp_valid), 64'(4'b0001 << e.id));
                    chk("rsp_grant_id", 64'(grant_id), 64'(e.id));
                    chk("rsp_product", 64'(rsp_product), 64'(e.p));
                end
            end
        end
    end

    function automatic bit cond(input int which, input int id);
        case (which)
            0:       return req_ready[id];
            1:       return mul_start;
            2:       return rsp_valid[id];
            default: return rq.size() == 0;
        endcase
    endfunction

    // Returns at the first negedge where the condition holds, or after a bounded wait.
    task automatic wait_for(input int which, input int id, input string nm);
        int t;
        t = 0;
        @(negedge clk);
        while (!cond(which, id)) begin
            t++;
            if (t > 100) begin fail_now(nm); return; end
            @(negedge clk);
        end
    endtask

    task automatic set_e(input int k, input int id, input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] p);
        tab_id[k] = id; tab_a[k] = a; tab_b[k] = b; tab_p[k] = p; used_e[k] = 1'b0;
    endtask

    task automatic load_reqs(input int n);
        bit f;
        for (int r = 0; r < NR; r++) begin
            f = 1'b0;
            req_valid[r] = 1'b0;
            for (int k = 0; k < n; k++) begin
                if (!f && !used_e[k] && tab_id[k] == r) begin
                    f = 1'b1;
                    req_valid[r] = 1'b1;
                    req_a[r*W +: W] = tab_a[k];
                    req_b[r*W +: W] = tab_b[k];
                end
            end
        end
    endtask

    // Table entries are listed in expected grant order; each requester presents its oldest entry.
    task automatic run_table(input int n);
        int done_cnt, t, g;
        bit f;
        rsp_t e;
        for (int k = 0; k < n; k++) begin
            gq.push_back(tab_id[k]);
            e.id = tab_id[k]; e.p = tab_p[k];
            rq.push_back(e);
        end
        load_reqs(n);
        done_cnt = 0;
        t = 0;
        while (done_cnt < n) begin
            @(negedge clk);
            t++;
            if (t > 200) begin fail_now("accept_timeout"); break; end
            if (|req_ready) begin
                g = 0;
                for (int r = 0; r < NR; r++) if (req_ready[r]) g = r;
                f = 1'b0;
                for (int k = 0; k < n; k++)
                    if (!f && !used_e[k] && tab_id[k] == g) begin used_e[k] = 1'b1; f = 1'b1; end
                done_cnt++;
                t = 0;
                @(posedge clk); #1;
                load_reqs(n);
                @(negedge clk);
                chk("start_after_accept", 64'(mul_start), 64'd1);
            end
        end
        wait_for(3, 0, "rsp_drain_timeout");
        @(posedge clk); #1;
    endtask

    initial begin
        rsp_t e;
        int s0;
        rst_n = 1'b0; en = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = '1;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_mul_start", 64'(mul_start), 64'd0);
        chk("rst_mul_a", 64'(mul_a), 64'd0);
        chk("rst_mul_b", 64'(mul_b), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_product", 64'(rsp_product), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_grant_id", 64'(grant_id), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Round robin 0,1,2,3,0 with all requesters pending.
        set_e(0, 0, 16'd3,    16'd5,    32'h0000_000F);
        set_e(1, 1, 16'hFFFE, 16'd4,    32'hFFFF_FFF8);
        set_e(2, 2, 16'd100,  16'd200,  32'h0000_4E20);
        set_e(3, 3, 16'hFFF9, 16'hFFF7, 32'h0000_003F);
        set_e(4, 0, 16'h7FFF, 16'h7FFF, 32'h3FFF_0001);
        run_table(5);

        // Single request: 7 * -3.
        set_e(0, 2, 16'd7, 16'hFFFD, 32'hFFFF_FFEB);
        run_table(1);

        // Stale done held two cycles past start.
        stale_cfg = 2;
        set_e(0, 1, 16'h1234, 16'd2, 32'h0000_2468);
        run_table(1);
        stale_cfg = 1;

        // Response backpressure on requester 1 while requester 3 waits.
        rsp_ready = 4'b1101;
        gq.push_back(1); gq.push_back(3);
        e.id = 1; e.p = 32'hFFFF_FA24; rq.push_back(e);
        e.id = 3; e.p = 32'h0000_008F; rq.push_back(e);
        req_valid[1] = 1'b1; req_a[1*W +: W] = 16'd300; req_b[1*W +: W] = 16'hFFFB;
        wait_for(0, 1, "bp_accept_timeout");
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        req_valid[3] = 1'b1; req_a[3*W +: W] = 16'd11; req_b[3*W +: W] = 16'd13;
        wait_for(2, 1, "bp_rsp_timeout");
        for (int c = 0; c < 10; c++) begin
            chk("bp_rsp_valid", 64'(rsp_valid), 64'h2);
            chk("bp_rsp_product", 64'(rsp_product), 64'hFFFF_FA24);
            chk("bp_req_ready", 64'(req_ready), 64'h0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        rsp_ready = '1;
        @(negedge clk);
        chk("bp_no_accept_in_resp", 64'(req_ready), 64'h0);
        @(negedge clk);
        chk("bp_req3_after_rsp", 64'(req_ready), 64'h8);
        @(posedge clk); #1;
        req_valid[3] = 1'b0;
        wait_for(3, 0, "bp_drain_timeout");
        @(posedge clk); #1;

        // Reset while requester 1 is in WAIT; ptr would otherwise be 2.
        gq.push_back(1);
        req_valid[1] = 1'b1; req_a[1*W +: W] = 16'd1000; req_b[1*W +: W] = 16'd1000;
        wait_for(0, 1, "rw_accept_timeout");
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        wait_for(1, 0, "rw_start_timeout");
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("rw_req_ready", 64'(req_ready), 64'd0);
        chk("rw_mul_start", 64'(mul_start), 64'd0);
        chk("rw_mul_a", 64'(mul_a), 64'd0);
        chk("rw_mul_b", 64'(mul_b), 64'd0);
        chk("rw_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rw_rsp_product", 64'(rsp_product), 64'd0);
        chk("rw_busy", 64'(busy), 64'd0);
        chk("rw_grant_id", 64'(grant_id), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        set_e(0, 0, 16'd2,    16'd3, 32'h0000_0006);
        set_e(1, 3, 16'hFFFF, 16'd1, 32'hFFFF_FFFF);
        run_table(2);

        // Enable dropped for the ISSUE cycle.
        gq.push_back(2);
        e.id = 2; e.p = 32'h0000_4000; rq.push_back(e);
        req_valid[2] = 1'b1; req_a[2*W +: W] = 16'hFF80; req_b[2*W +: W] = 16'hFF80;
        wait_for(0, 2, "en_accept_timeout");
        s0 = starts;
        @(posedge clk); #1;
        en = 1'b0;
        req_valid[2] = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("en_no_start", 64'(mul_start), 64'd0);
        end
        @(posedge clk); #1;
        en = 1'b1;
        @(negedge clk);
        chk("en_start_resume", 64'(mul_start), 64'd1);
        @(negedge clk);
        chk("en_start_single", 64'(mul_start), 64'd0);
        wait_for(3, 0, "en_drain_timeout");
        chk("en_start_count", 64'(starts - s0), 64'd1);

        repeat (5) @(negedge clk);
        chk("grant_queue_empty", 64'(gq.size()), 64'd0);
        chk("rsp_queue_empty", 64'(rq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "global timeout");
    end

endmodule
